// File: rtl/mainfsm_ahb.sv
// Main control FSM of the multicycle ARM core with an AHB-attached memory.
// Sequences fetch/decode/execute/memory/writeback and stalls bus states on HReady.
module mainfsm_ahb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       HReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       MemReq,
    output logic       Undef,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    // Held as plain bits so the unused encodings 11-15 stay representable.
    logic [3:0] state_q;
    logic [3:0] state_d;

    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        MemReq    = 1'b0;
        Undef     = 1'b0;

        case (state_q)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = HReady;
                NextPC    = HReady;
                state_d   = HReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                state_d = HReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_d = HReady ? FETCH : MEMWR;
            end
            EXECUTER: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            UNKNOWN: begin
                Undef = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset clears the state asynchronously, so selects already show FETCH; only enables need masking.
        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
            MemReq  = 1'b0;
            Undef   = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mainfsm_ahb.sv
// Self-checking bench for mainfsm_ahb: directed scenarios plus randomized instruction
// streams compared against a per-instruction state-trace model.
module tb_mainfsm_ahb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       HReady = 1'b1;
    logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, MemReq, Undef;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXR = 6, S_EXI = 7, S_ALUWB = 8, S_BRANCH = 9, S_UNK = 10;

    typedef struct packed {
        logic       irw, npc, regw, memw, br, aluop, adrsrc, memreq, undef;
        logic [1:0] srca, srcb, ressrc;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        int         st;
        logic       hr;
        logic [1:0] op;
        logic [5:0] funct;
    } step_t;

    outs_t obs;
    step_t trace[$];

    assign obs = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, MemReq, Undef,
                  ALUSrcA, ALUSrcB, ResultSrc, State};

    mainfsm_ahb dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .HReady(HReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .ALUOp(ALUOp), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .MemReq(MemReq), .Undef(Undef), .State(State)
    );

    always #5 clk = ~clk;

    // Output table per state, read straight from the control-signal description.
    function automatic outs_t expect_outs(input int st, input logic hr);
        outs_t e = '0;
        e.state = st[3:0];
        case (st)
            S_FETCH:  begin e.memreq = 1; e.srca = 2'b01; e.srcb = 2'b10; e.ressrc = 2'b10; e.irw = hr; e.npc = hr; end
            S_DECODE: begin e.srca = 2'b01; e.srcb = 2'b10; e.ressrc = 2'b10; end
            S_MEMADR: begin e.srcb = 2'b01; end
            S_MEMRD:  begin e.memreq = 1; e.adrsrc = 1; end
            S_MEMWB:  begin e.ressrc = 2'b01; e.regw = 1; end
            S_MEMWR:  begin e.memreq = 1; e.adrsrc = 1; e.memw = 1; end
            S_EXR:    begin e.aluop = 1; end
            S_EXI:    begin e.srcb = 2'b01; e.aluop = 1; end
            S_ALUWB:  begin e.regw = 1; end
            S_BRANCH: begin e.srca = 2'b10; e.srcb = 2'b01; e.ressrc = 2'b10; e.br = 1; end
            default:  begin e.undef = 1; end
        endcase
        return e;
    endfunction

    function automatic void push(input int st, input logic hr, input logic [1:0] op, input logic [5:0] funct);
        step_t s;
        s.st = st; s.hr = hr; s.op = op; s.funct = funct;
        trace.push_back(s);
    endfunction

    // Builds the expected cycle-by-cycle walk of one instruction; HReady is random where it must not matter.
    function automatic void build(input logic [1:0] op, input logic [5:0] funct, input int fw, input int mw);
        trace.delete();
        for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, 2'($urandom), 6'($urandom));
        push(S_FETCH, 1'b1, 2'($urandom), 6'($urandom));
        push(S_DECODE, 1'($urandom), op, funct);
        case (op)
            2'b00: begin
                push(funct[5] ? S_EXI : S_EXR, 1'($urandom), op, funct);
                push(S_ALUWB, 1'($urandom), op, funct);
            end
            2'b01: begin
                push(S_MEMADR, 1'($urandom), op, funct);
                for (int i = 0; i < mw; i++) push(funct[0] ? S_MEMRD : S_MEMWR, 1'b0, op, funct);
                push(funct[0] ? S_MEMRD : S_MEMWR, 1'b1, op, funct);
                if (funct[0]) push(S_MEMWB, 1'($urandom), op, funct);
            end
            2'b10:   push(S_BRANCH, 1'($urandom), op, funct);
            default: push(S_UNK, 1'($urandom), op, funct);
        endcase
    endfunction

    task automatic applyStimulus(input step_t s);
        @(negedge clk);
        reset  = 1'b0;
        HReady = s.hr;
        Op     = s.op;
        Funct  = s.funct;
        #1;
    endtask

    task automatic test_reset();
        outs_t e;
        e = expect_outs(S_FETCH, 1'b1);
        e.irw = 0; e.npc = 0; e.memreq = 0;
        #2;
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_initial: got %h expected %h", obs, e); end
        @(negedge clk); #1;
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_held: got %h expected %h", obs, e); end
    endtask

    task automatic test_dataproc();
        for (int k = 0; k < 2; k++) begin
            build(2'b00, k == 0 ? 6'b000000 : 6'b100000, 0, 0);
            foreach (trace[i]) begin
                applyStimulus(trace[i]);
                checks++;
                if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                    errors++;
                    $display("[TB] FAIL dataproc%0d step %0d: got %h expected %h", k, i, obs, expect_outs(trace[i].st, trace[i].hr));
                end
            end
        end
    endtask

    task automatic test_fetch_wait();
        int pulses = 0;
        build(2'b10, 6'b0, 3, 0);
        foreach (trace[i]) begin
            applyStimulus(trace[i]);
            pulses += int'(NextPC);
            checks++;
            if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                errors++;
                $display("[TB] FAIL fetch_wait step %0d: got %h expected %h", i, obs, expect_outs(trace[i].st, trace[i].hr));
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("[TB] FAIL fetch_wait_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_load_store();
        for (int k = 0; k < 2; k++) begin
            build(2'b01, k == 0 ? 6'b000001 : 6'b000000, 0, k == 0 ? 2 : 1);
            foreach (trace[i]) begin
                applyStimulus(trace[i]);
                checks++;
                if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                    errors++;
                    $display("[TB] FAIL %s step %0d: got %h expected %h", k == 0 ? "ldr" : "str", i, obs, expect_outs(trace[i].st, trace[i].hr));
                end
            end
        end
    endtask

    task automatic test_branch_undef();
        for (int k = 0; k < 2; k++) begin
            build(k == 0 ? 2'b10 : 2'b11, 6'($urandom), 0, 0);
            foreach (trace[i]) begin
                applyStimulus(trace[i]);
                checks++;
                if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                    errors++;
                    $display("[TB] FAIL %s step %0d: got %h expected %h", k == 0 ? "branch" : "undef", i, obs, expect_outs(trace[i].st, trace[i].hr));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        outs_t e;
        build(2'b01, 6'b000001, 0, 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(trace[i]);
            checks++;
            if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre step %0d: got %h expected %h", i, obs, expect_outs(trace[i].st, trace[i].hr));
            end
        end
        #2 reset = 1'b1;
        #1;
        e = expect_outs(S_FETCH, 1'b0);
        e.memreq = 0;
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_mid_async: got %h expected %h", obs, e); end
        @(negedge clk);
        HReady = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_mid_held: got %h expected %h", obs, e); end
        build(2'b00, 6'b000000, 1, 0);
        foreach (trace[i]) begin
            applyStimulus(trace[i]);
            checks++;
            if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                errors++;
                $display("[TB] FAIL reset_mid_after step %0d: got %h expected %h", i, obs, expect_outs(trace[i].st, trace[i].hr));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int pulses = 0;
            build(2'($urandom), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (trace[i]) begin
                applyStimulus(trace[i]);
                pulses += int'(NextPC);
                checks++;
                if (obs !== expect_outs(trace[i].st, trace[i].hr)) begin
                    errors++;
                    $display("[TB] FAIL random%0d step %0d: got %h expected %h", n, i, obs, expect_outs(trace[i].st, trace[i].hr));
                end
            end
            checks++;
            if (pulses !== 1) begin errors++; $display("[TB] FAIL random%0d_pulses: got %0d expected 1", n, pulses); end
        end
    endtask

    initial begin
        test_reset();
        test_dataproc();
        test_fetch_wait();
        test_load_store();
        test_branch_undef();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mainfsm_ahb.md
Name: mainfsm_ahb

Overview:
- Main control state machine of the multicycle ARM core on the AHB-attached memory.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives the datapath mux selects, and drives PCS-path inputs NextPC, RegW, MemW and Branch into the downstream conditional-write logic, which gates them with the condition check.
- Stalls in bus-access states until the AHB slave signals HReady.

Parameters:
- None. State encoding is fixed: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- Op  in  2  instruction[27:26], stable from DECODE onward
- Funct  in  6  instruction[25:20]; bit5 = I (immediate), bit0 = L/S
- HReady  in  1  AHB transfer-complete, sampled on clk rising edge
- IRWrite  out  1  instruction register load enable
- NextPC  out  1  PC advance request
- RegW  out  1  register write request (pre-condition)
- MemW  out  1  memory write request (pre-condition)
- Branch  out  1  branch request (pre-condition)
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = ADD
- AdrSrc  out  1  0 = PC, 1 = ALU result register
- ALUSrcA  out  2  00 = Rn, 01 = PC, 10 = ALUOut
- ALUSrcB  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- MemReq  out  1  bus transfer request (AHB NONSEQ)
- Undef  out  1  undefined-op pulse
- State  out  4  current state, for debug and verification

Behaviour:
- Single state register, updated on clk rising edge, asynchronously cleared to FETCH by reset.
- All outputs decoded combinationally from State and HReady (Moore outputs, plus HReady qualification where listed).
- While reset=1, all enables are forced to 0: IRWrite, NextPC, RegW, MemW, Branch, MemReq, Undef. Selects take their FETCH values.
- Per-state outputs (signals not listed are 0):
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=HReady.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: MemReq=1, AdrSrc=1, MemW=1 for every wait cycle.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: Undef=1.
- Transitions:
  - FETCH goes to DECODE if HReady, else stays in FETCH.
  - DECODE goes to:
    - MEMADR if Op=01
    - EXECUTEI if Op=00 and Funct[5]=1
    - EXECUTER if Op=00 and Funct[5]=0
    - BRANCH if Op=10
    - UNKNOWN if Op=11
  - MEMADR goes to MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD goes to MEMWB if HReady, else stays in MEMRD.
  - MEMWR goes to FETCH if HReady, else stays in MEMWR.
  - EXECUTER and EXECUTEI go to ALUWB.
  - MEMWB, ALUWB, BRANCH and UNKNOWN go to FETCH.
- Boundary conditions:
  - Wait states: IRWrite and NextPC pulse exactly once per fetch, in the HReady=1 cycle. No double PC increment under any stall length.
  - Selects and AdrSrc are held constant through all wait cycles of a bus state.
  - HReady is ignored in non-bus states.
  - Reset asserted mid-operation returns State to FETCH immediately, with no clock required. On the first clk edge after deassertion, FETCH is evaluated normally.
  - Op and Funct are ignored outside DECODE and MEMADR.
  - Encodings 11–15 are unreachable. If reached, the next state is FETCH and all enables are 0.
- Latency with HReady=1 (cycles):
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - branch: 3
  - undefined: 3

Test Plan:
- ADD register (Op=00, Funct=000000), HReady=1 -> State 0,1,6,8,0. RegW=1 only in cycle 4. ALUOp=1 in cycle 3. NextPC pulses once.
- ADD immediate (Funct[5]=1) -> State 0,1,7,8,0, with ALUSrcB=01 in EXECUTEI.
- FETCH with HReady low for 3 cycles -> State stays 0 for 4 cycles. IRWrite and NextPC are high only in cycle 4, i.e. a single pulse.
- LDR (Op=01, Funct[0]=1) with HReady low for 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMRD. RegW with ResultSrc=01 in MEMWB.
- STR (Funct[0]=0) with 1 wait cycle -> State 0,1,2,5,5,0. MemW=1 and MemReq=1 in both MEMWR cycles.
- Branch (Op=10) -> State 0,1,9,0 with Branch=1 and ALUSrcA=10 in BRANCH.
- Op=11 -> State 0,1,10,0 with a one-cycle Undef pulse.
- Reset asserted between clock edges while in MEMRD -> State reads 0 before the next edge and MemReq=0 while reset is held. After release the fetch completes normally.
